// File: rtl/digit_feeder_pkg.sv
// Shared types and default sizing for the digit feeder datapath.
package digit_feeder_pkg;
    localparam int NDIGITS_DEF = 8;
    localparam int DIGIT_W_DEF = 4;

    typedef logic [NDIGITS_DEF*DIGIT_W_DEF-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/digit_shifter.sv
// Remaining-digit register, position counter and end-of-word detect.
// DIGIT_FEEDER_SKIP_ZERO_EN: end the word at its highest non-zero digit.
module digit_shifter
    import digit_feeder_pkg::*;
#(
    parameter int NDIGITS = NDIGITS_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF,
    localparam int WW     = NDIGITS*DIGIT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [WW-1:0]      word_i,
    input  logic [WW-1:0]      main_i,
    input  logic               xfer_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               avail_o,
    output logic               last_o
);
    localparam int CW = $clog2(NDIGITS) + 1;

    logic [WW-1:0] src_q, src_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign digit_o = src_q[DIGIT_W-1:0];

`ifdef DIGIT_FEEDER_SKIP_ZERO_EN
    // An all-zero source means nothing is left to present, including main==0.
    assign last_o  = (src_q >> DIGIT_W) == '0;
    assign avail_o = src_q != '0;
`else
    assign last_o  = cnt_q == CW'(NDIGITS - 1);
    assign avail_o = 1'b1;
`endif

    always_comb begin
        src_d = src_q;
        cnt_d = cnt_q;
        if (load_i) begin
            src_d = word_i;
            cnt_d = '0;
        end else if (xfer_i) begin
            if (last_o) begin
                src_d = main_i;
                cnt_d = '0;
            end else begin
                src_d = src_q >> DIGIT_W;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/digit_feeder.sv
// Streams a loaded word one digit per accepted cycle, LSD first, building X_out.
// DIGIT_FEEDER_SKIP_ZERO_EN (in digit_shifter): skip leading zero digits.
module digit_feeder
    import digit_feeder_pkg::*;
#(
    parameter int NDIGITS = NDIGITS_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF,
    localparam int WW     = NDIGITS*DIGIT_W
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Load,
    input  logic [WW-1:0]      Word,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Ready,
    output logic               Valid,
    output logic [DIGIT_W-1:0] Digit,
    output logic [WW-1:0]      X_out,
    output logic               Wrap,
    output logic               Busy
);
    state_t        state_q, state_d;
    logic [WW-1:0] main_q, acc_q, acc_d;
    logic          wrap_q, wrap_d;
    logic          avail, last, xfer;

    digit_shifter #(.NDIGITS(NDIGITS), .DIGIT_W(DIGIT_W)) u_shift (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .load_i  (Load),
        .word_i  (Word),
        .main_i  (main_q),
        .xfer_i  (xfer),
        .digit_o (Digit),
        .avail_o (avail),
        .last_o  (last)
    );

    assign Busy  = state_q == RUN;
    assign Valid = Busy && avail;
    // A same-cycle Load wins; the offered digit is simply not consumed.
    assign xfer  = Valid && Ready && !Load;
    assign X_out = acc_q;
    assign Wrap  = wrap_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start && !Stop) state_d = RUN;
            RUN:     if (Stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (xfer) begin
            acc_d  = {acc_q[WW-DIGIT_W-1:0], Digit};
            wrap_d = last;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            main_q  <= '0;
            acc_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wrap_q  <= wrap_d;
            if (Load) main_q <= Word;
        end
    end
endmodule

// File: tb/tb_digit_feeder.sv
// Randomized and directed check of digit_feeder against a digit-queue model.
module tb_digit_feeder;
    import digit_feeder_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst_n, Load, Start, Stop, Ready;
    word_t      Word;
    logic       Valid, Wrap, Busy;
    logic [3:0] Digit;
    word_t      X_out;

    digit_feeder dut (
        .Clk(Clk), .Rst_n(Rst_n), .Load(Load), .Word(Word), .Start(Start),
        .Stop(Stop), .Ready(Ready), .Valid(Valid), .Digit(Digit),
        .X_out(X_out), .Wrap(Wrap), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: digits still to send (LSD first), loaded word, accumulator, run flag.
    int    q[$];
    word_t mmain, macc;
    bit    mrun, mwrap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_q(input word_t w);
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(int'((w >> (4*i)) & 32'hF));
`ifdef DIGIT_FEEDER_SKIP_ZERO_EN
        while (q.size() > 0 && q[q.size()-1] == 0) void'(q.pop_back());
`endif
    endtask

    task automatic model_reset();
        mrun = 0; mwrap = 0; mmain = '0; macc = '0;
        load_q('0);
    endtask

    task automatic check_outputs();
        bit mvalid;
        int mdig;
        mvalid = mrun && q.size() > 0;
        mdig   = (q.size() > 0) ? q[0] : 0;
        chk("valid", 32'(Valid), 32'(mvalid));
        chk("digit", 32'(Digit), mdig);
        chk("x_out", X_out, macc);
        chk("wrap",  32'(Wrap), 32'(mwrap));
        chk("busy",  32'(Busy), 32'(mrun));
    endtask

    // Called at a negedge: check, drive, advance model over the next posedge.
    task automatic cyc(input bit l, input word_t w, input bit s, input bit p, input bit r);
        bit v, x;
        check_outputs();
        Load = l; Word = w; Start = s; Stop = p; Ready = r;
        v = mrun && q.size() > 0;
        x = v && r && !l;
        mwrap = 0;
        if (l) begin
            mmain = w;
            load_q(w);
        end else if (x) begin
            macc = {macc[27:0], 4'(q[0])};
            void'(q.pop_front());
            if (q.size() == 0) begin
                mwrap = 1;
                load_q(mmain);
            end
        end
        if (mrun) begin
            if (p) mrun = 0;
        end else if (s && !p) mrun = 1;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic mid_reset();
        Rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1 Rst_n = 1'b1;
    endtask

    initial begin
        word_t w;
        Rst_n = 1'b0; Load = 0; Word = '0; Start = 0; Stop = 0; Ready = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        check_outputs();
        Rst_n = 1'b1;

        // Full-word stream
        cyc(1, 32'h01806177, 0, 0, 0);
        cyc(0, '0, 1, 0, 1);
        repeat (8) cyc(0, '0, 0, 0, 1);
`ifdef DIGIT_FEEDER_SKIP_ZERO_EN
        chk("x_out_8xfer", X_out, 32'h77160817);
`else
        chk("x_out_8xfer", X_out, 32'h77160810);
        chk("wrap_8th", 32'(Wrap), 32'd1);
`endif
        chk("digit_after", 32'(Digit), 32'd7);

        // Ready stall, stop/resume, load against transfer
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 1, 1);
        repeat (2) cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 0, 0, 1);
        cyc(1, 32'h0000ABCD, 0, 0, 1);
        chk("digit_after_load", 32'(Digit), 32'hD);
        repeat (5) cyc(0, '0, 0, 0, 1);

        // Reset mid-stream, then Start without Load
        mid_reset();
        cyc(0, '0, 1, 0, 1);
        repeat (3) cyc(0, '0, 0, 0, 1);

        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            w = w >> (4 * $urandom_range(0, 8));
            if (i == 300) mid_reset();
            cyc(($urandom_range(0, 15) == 0), w, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
